// File: rtl/pe_array_sequencer_if.sv
// PE-array sequencer bus: layer config in, control strobes out.
// Master is the layer controller, slave is the sequencer.
interface pe_array_sequencer_if #(
  parameter int N_PE      = 16,
  parameter int ADDR_FIFO = 9,
  parameter int ROW_W     = 10,
  parameter int BANK_W    = 8
);
  logic                 start;
  logic [ADDR_FIFO-1:0] cfg_row_length;
  logic [ROW_W-1:0]     cfg_n_rows;
  logic [2:0]           cfg_kernel;
  logic [BANK_W-1:0]    cfg_n_banks;
  logic                 cfg_pool_enable;
  logic                 cfg_nl_enable;
  logic [2:0]           cfg_pool_nl;
  logic [2:0]           cfg_nl_type;
  logic                 data_valid;

  logic                 busy;
  logic                 done;
  logic                 err_cfg;
  logic                 shifting_line;
  logic                 line_buffer_reset;
  logic                 mac_enable;
  logic                 adder_enable;
  logic                 final_filter_bank;
  logic [ADDR_FIFO-1:0] row_length;
  logic [N_PE-1:0]      shifting_filter;
  logic                 shifting_line_pool;
  logic                 line_buffer_reset_pool;
  logic [ADDR_FIFO-1:0] row_length_pool;
  logic [2:0]           pool_nl;
  logic [2:0]           nl_type;
  logic                 nl_enable;
  logic                 pool_enable;

  modport master (
    output start, cfg_row_length, cfg_n_rows,
    output cfg_kernel, cfg_n_banks,
    output cfg_pool_enable, cfg_nl_enable,
    output cfg_pool_nl, cfg_nl_type, data_valid,
    input  busy, done, err_cfg,
    input  shifting_line, line_buffer_reset,
    input  mac_enable, adder_enable,
    input  final_filter_bank, row_length,
    input  shifting_filter, shifting_line_pool,
    input  line_buffer_reset_pool, row_length_pool,
    input  pool_nl, nl_type, nl_enable, pool_enable
  );

  modport slave (
    input  start, cfg_row_length, cfg_n_rows,
    input  cfg_kernel, cfg_n_banks,
    input  cfg_pool_enable, cfg_nl_enable,
    input  cfg_pool_nl, cfg_nl_type, data_valid,
    output busy, done, err_cfg,
    output shifting_line, line_buffer_reset,
    output mac_enable, adder_enable,
    output final_filter_bank, row_length,
    output shifting_filter, shifting_line_pool,
    output line_buffer_reset_pool, row_length_pool,
    output pool_nl, nl_type, nl_enable, pool_enable
  );
endinterface

// File: rtl/pe_array_sequencer.sv
// PE-array control sequencer: walks each filter bank through
// line-buffer reset, filter load, prime, row compute and drain.
module pe_array_sequencer #(
  parameter int N_PE      = 16,
  parameter int ADDR_FIFO = 9,
  parameter int ROW_W     = 10,
  parameter int BANK_W    = 8,
  parameter int KMAX      = 5,
  parameter int ADDER_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  pe_array_sequencer_if.slave bus
);

  localparam int KW = $clog2(KMAX * KMAX + 1);
  localparam int PW = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int DW = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LB_RST,
    S_FLOAD,
    S_PRIME,
    S_ROW,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]           k_q;
  logic [KW-1:0]        kk_q;
  logic [ADDR_FIFO-1:0] rl_q;
  logic [ROW_W-1:0]     nr_q;
  logic [BANK_W-1:0]    nb_q;
  logic                 pool_en_q;
  logic                 nl_en_q;
  logic [2:0]           pool_nl_q;
  logic [2:0]           nl_type_q;

  logic [BANK_W-1:0]    bank_q;
  logic [KW-1:0]        kk_cnt;
  logic [PW-1:0]        pe_q;
  logic [ADDR_FIFO-1:0] col_q;
  logic [2:0]           prow_q;
  logic [ROW_W-1:0]     row_q;
  logic [DW-1:0]        drn_q;
  logic [ADDER_LAT-1:0] mac_dly;
  logic                 err_q;

  logic cfg_ok, accept, dv, active;
  logic kk_last, pe_last, col_last;
  logic prow_last, row_last, drn_last;
  logic bank_last, mac_raw;

  // Config legality check and per-state terminal-count flags
  always_comb begin
    cfg_ok = (bus.cfg_kernel != 3'd0)
      && (32'(bus.cfg_kernel) <= 32'(KMAX))
      && (bus.cfg_row_length >= ADDR_FIFO'(bus.cfg_kernel))
      && (bus.cfg_n_rows >= ROW_W'(bus.cfg_kernel))
      && (bus.cfg_n_banks != '0);
    accept    = (state_q == S_IDLE) && bus.start && cfg_ok;
    dv        = bus.data_valid;
    active    = (state_q != S_IDLE);
    kk_last   = (kk_cnt == kk_q - KW'(1));
    pe_last   = (pe_q == PW'(N_PE - 1));
    col_last  = (col_q == rl_q - ADDR_FIFO'(1));
    prow_last = (prow_q == k_q - 3'd2);
    row_last  = (row_q == nr_q - ROW_W'(k_q));
    drn_last  = (drn_q == DW'(ADDER_LAT - 1));
    bank_last = (bank_q == nb_q - BANK_W'(1));
    mac_raw   = (state_q == S_ROW) && dv
      && (col_q >= ADDR_FIFO'(k_q) - ADDR_FIFO'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; work states advance only on valid words
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_LB_RST;
      S_LB_RST: state_d = S_FLOAD;
      S_FLOAD:
        if (dv && kk_last && pe_last)
          state_d = (k_q == 3'd1) ? S_ROW : S_PRIME;
      S_PRIME:
        if (dv && col_last && prow_last) state_d = S_ROW;
      S_ROW:
        if (dv && col_last && row_last) state_d = S_DRAIN;
      S_DRAIN:
        if (drn_last) state_d = bank_last ? S_DONE : S_LB_RST;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Config latch and bank/filter/column/row/drain counters
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q       <= '0;
      kk_q      <= '0;
      rl_q      <= '0;
      nr_q      <= '0;
      nb_q      <= '0;
      pool_en_q <= 1'b0;
      nl_en_q   <= 1'b0;
      pool_nl_q <= '0;
      nl_type_q <= '0;
      bank_q    <= '0;
      kk_cnt    <= '0;
      pe_q      <= '0;
      col_q     <= '0;
      prow_q    <= '0;
      row_q     <= '0;
      drn_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            k_q       <= bus.cfg_kernel;
            kk_q      <= KW'(bus.cfg_kernel)
                       * KW'(bus.cfg_kernel);
            rl_q      <= bus.cfg_row_length;
            nr_q      <= bus.cfg_n_rows;
            nb_q      <= bus.cfg_n_banks;
            pool_en_q <= bus.cfg_pool_enable;
            nl_en_q   <= bus.cfg_nl_enable;
            pool_nl_q <= bus.cfg_pool_nl;
            nl_type_q <= bus.cfg_nl_type;
            bank_q    <= '0;
          end
        end
        S_LB_RST: begin
          kk_cnt <= '0;
          pe_q   <= '0;
          col_q  <= '0;
          prow_q <= '0;
          row_q  <= '0;
          drn_q  <= '0;
        end
        S_FLOAD: begin
          if (dv) begin
            if (kk_last) begin
              kk_cnt <= '0;
              pe_q   <= pe_last ? '0 : pe_q + PW'(1);
            end else begin
              kk_cnt <= kk_cnt + KW'(1);
            end
          end
        end
        S_PRIME: begin
          if (dv) begin
            if (col_last) begin
              col_q  <= '0;
              prow_q <= prow_q + 3'd1;
            end else begin
              col_q <= col_q + ADDR_FIFO'(1);
            end
          end
        end
        S_ROW: begin
          if (dv) begin
            if (col_last) begin
              col_q <= '0;
              row_q <= row_q + ROW_W'(1);
            end else begin
              col_q <= col_q + ADDR_FIFO'(1);
            end
          end
        end
        S_DRAIN: begin
          drn_q <= drn_q + DW'(1);
          if (drn_last && !bank_last)
            bank_q <= bank_q + BANK_W'(1);
        end
        default: ;
      endcase
    end
  end

  // mac_enable delay line feeding adder_enable
  always_ff @(posedge clk) begin
    if (rst) mac_dly <= '0;
    else     mac_dly <= (mac_dly << 1) | ADDER_LAT'(mac_raw);
  end

  // Rejected-start pulse, one cycle after the start edge
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == S_IDLE) && bus.start && !cfg_ok;
  end

  // Strobe and pass-through output decode
  always_comb begin
    bus.busy              = active && (state_q != S_DONE);
    bus.done              = (state_q == S_DONE);
    bus.err_cfg           = err_q;
    bus.shifting_line     = dv && ((state_q == S_PRIME)
                                || (state_q == S_ROW));
    bus.line_buffer_reset = (state_q == S_LB_RST);
    bus.mac_enable        = mac_raw;
    bus.adder_enable      = mac_dly[ADDER_LAT-1];
    bus.final_filter_bank = active && bank_last;
    bus.row_length        = '0;
    bus.shifting_filter   = '0;
    bus.shifting_line_pool     = 1'b0;
    bus.line_buffer_reset_pool = 1'b0;
    bus.row_length_pool   = '0;
    bus.pool_nl           = '0;
    bus.nl_type           = '0;
    bus.nl_enable         = 1'b0;
    bus.pool_enable       = 1'b0;
    if ((state_q == S_FLOAD) && dv)
      bus.shifting_filter = N_PE'(1) << pe_q;
    if (active) begin
      bus.row_length      = rl_q;
      bus.row_length_pool = rl_q - ADDR_FIFO'(k_q)
                          + ADDR_FIFO'(1);
      bus.pool_nl         = pool_nl_q;
      bus.nl_type         = nl_type_q;
      bus.nl_enable       = nl_en_q;
      bus.pool_enable     = pool_en_q;
      bus.shifting_line_pool =
        mac_dly[ADDER_LAT-1] && pool_en_q;
      bus.line_buffer_reset_pool =
        (state_q == S_LB_RST) && pool_en_q;
    end
  end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer with N_PE=4.
// Strobe counts and run lengths are hand-computed constants.
module tb_pe_array_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pe_array_sequencer_if #(
    .N_PE(4), .ADDR_FIFO(9), .ROW_W(10), .BANK_W(8)
  ) bus ();

  pe_array_sequencer #(
    .N_PE(4), .ADDR_FIFO(9), .ROW_W(10), .BANK_W(8),
    .KMAX(5), .ADDER_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  int mac_cnt, add_cnt, add_bad, fb_cnt, fb_first;
  int lbr_cnt, lbrp_cnt, slp_cnt, slp_bad;
  int stall_strobe, sf_cnt;
  int rl_s, rlp_s, pnl_s;
  int n;

  logic [39:0] all_out;
  assign all_out = {
    bus.busy, bus.done, bus.err_cfg, bus.shifting_line,
    bus.line_buffer_reset, bus.mac_enable,
    bus.adder_enable, bus.final_filter_bank,
    bus.row_length, bus.shifting_filter,
    bus.shifting_line_pool, bus.line_buffer_reset_pool,
    bus.row_length_pool, bus.pool_nl, bus.nl_type,
    bus.nl_enable, bus.pool_enable
  };

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [2:0] k,
                         input logic [8:0] rl,
                         input logic [9:0] nr,
                         input logic [7:0] nb,
                         input logic pe);
    bus.cfg_kernel      = k;
    bus.cfg_row_length  = rl;
    bus.cfg_n_rows      = nr;
    bus.cfg_n_banks     = nb;
    bus.cfg_pool_enable = pe;
    bus.cfg_nl_enable   = pe;
    bus.cfg_pool_nl     = pe ? 3'd5 : 3'd0;
    bus.cfg_nl_type     = pe ? 3'd2 : 3'd0;
  endtask

  // mode 0: steady valid, 1: valid toggling, 2: start while busy
  task automatic run(input int mode, output int cyc);
    int k;
    logic m1, m2, a;
    mac_cnt = 0; add_cnt = 0; add_bad = 0;
    fb_cnt = 0; fb_first = 0; lbr_cnt = 0;
    lbrp_cnt = 0; slp_cnt = 0; slp_bad = 0;
    stall_strobe = 0; sf_cnt = 0;
    rl_s = 0; rlp_s = 0; pnl_s = 0;
    m1 = 1'b0; m2 = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 1;
    while (k < 1000) begin
      if (mode == 1) bus.data_valid = (k % 2 == 1);
      if (mode == 2 && k == 50) begin
        bus.start = 1'b1;
        bus.cfg_kernel = 3'd1;
        bus.cfg_n_banks = 8'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      a = bus.adder_enable;
      if (a !== m2) add_bad++;
      m2 = m1;
      m1 = bus.mac_enable;
      mac_cnt += int'(bus.mac_enable);
      add_cnt += int'(a);
      sf_cnt += $countones(bus.shifting_filter);
      lbr_cnt += int'(bus.line_buffer_reset);
      lbrp_cnt += int'(bus.line_buffer_reset_pool);
      slp_cnt += int'(bus.shifting_line_pool);
      if (bus.shifting_line_pool !== (a & bus.pool_enable))
        slp_bad++;
      if (bus.final_filter_bank) begin
        fb_cnt++;
        if (fb_first == 0) fb_first = k;
      end
      if (!bus.data_valid && (bus.shifting_line
          || bus.mac_enable || (|bus.shifting_filter)))
        stall_strobe++;
      if (k == 1) begin
        rl_s = int'(bus.row_length);
        rlp_s = int'(bus.row_length_pool);
        pnl_s = int'(bus.pool_nl);
      end
      if (bus.done) break;
      @(posedge clk); #1;
      k++;
    end
    bus.data_valid = 1'b1;
    bus.start = 1'b0;
    cyc = k;
  endtask

  task automatic illegal(input logic [2:0] k,
                         input logic [8:0] rl,
                         input logic [7:0] nb,
                         input string tag);
    set_cfg(k, rl, 10'd5, nb, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_err"}, bus.err_cfg, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_quiet"}, |all_out, 0);
    set_cfg(3'd3, 9'd8, 10'd5, 8'd2, 1'b0);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0;
    bus.data_valid = 1'b1;
    set_cfg(3'd3, 9'd8, 10'd5, 8'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", |all_out, 0);

    run(0, n);
    chk("base_done_cyc", n, 159);
    chk("base_mac", mac_cnt, 36);
    chk("base_adder", add_cnt, 36);
    chk("base_adder_lag", add_bad, 0);
    chk("base_sf", sf_cnt, 72);
    chk("base_lbr", lbr_cnt, 2);
    chk("base_fb_cnt", fb_cnt, 80);
    chk("base_fb_first", fb_first, 80);
    chk("base_rl", rl_s, 8);
    chk("base_rlp", rlp_s, 6);
    chk("base_done_busy", bus.busy, 0);

    run(1, n);
    chk("stall_done_cyc", n, 310);
    chk("stall_mac", mac_cnt, 36);
    chk("stall_adder", add_cnt, 36);
    chk("stall_sf", sf_cnt, 72);
    chk("stall_adder_lag", add_bad, 0);
    chk("stall_strobe", stall_strobe, 0);

    illegal(3'd0, 9'd8, 8'd2, "k0");
    illegal(3'd6, 9'd8, 8'd2, "k6");
    illegal(3'd3, 9'd2, 8'd2, "rl2");
    illegal(3'd3, 9'd8, 8'd0, "nb0");

    run(2, n);
    chk("restart_done_cyc", n, 159);
    chk("restart_mac", mac_cnt, 36);
    chk("restart_lbr", lbr_cnt, 2);
    set_cfg(3'd3, 9'd8, 10'd5, 8'd2, 1'b0);

    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (58) @(posedge clk);
    #1;
    chk("midrow_mac_live", bus.mac_enable, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrow_rst_outs", |all_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      dn += int'(bus.done) + int'(bus.adder_enable);
    end
    chk("midrow_no_done", dn, 0);
    run(0, n);
    chk("after_rst_cyc", n, 159);
    chk("after_rst_mac", mac_cnt, 36);

    set_cfg(3'd1, 9'd4, 10'd2, 8'd1, 1'b1);
    run(0, n);
    chk("pool_done_cyc", n, 16);
    chk("pool_slp", slp_cnt, 8);
    chk("pool_slp_mirror", slp_bad, 0);
    chk("pool_rlp", rlp_s, 4);
    chk("pool_lbrp", lbrp_cnt, 1);
    chk("pool_nl", pnl_s, 5);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_array_sequencer.md
# pe_array_sequencer

Parametrised control sequencer for the PE array: latches a per-layer convolution descriptor and generates, cycle by cycle, the full set of PE-array control strobes (line-buffer shift/reset, per-PE filter load, MAC/adder enables, filter-bank marker, pool and non-linearity controls). It sits between the layer controller and the PE array control interface, replacing hand-driven strobes. It generalises PE count, kernel size, bank count and adder latency, and adds stall handling and configuration checking.

## Interface
- N_PE, 16, number of PEs (width of shifting_filter)
- ADDR_FIFO, 9, line-buffer address / row_length width
- ROW_W, 10, row-count width
- BANK_W, 8, filter-bank count width
- KMAX, 5, largest supported kernel (K×K)
- ADDER_LAT, 2, cycles from mac_enable to matching adder_enable
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; accepted only in IDLE
- cfg_row_length  in  ADDR_FIFO  input row width
- cfg_n_rows  in  ROW_W  input row count
- cfg_kernel  in  3  K
- cfg_n_banks  in  BANK_W  filter banks to run
- cfg_pool_enable, cfg_nl_enable  in  1 each  pass-through enables
- cfg_pool_nl, cfg_nl_type  in  3 each  pass-through mode selects
- data_valid  in  1  input stream has a word this cycle; 0 = stall
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at completion
- err_cfg  out  1  one-cycle pulse on rejected start
- shifting_line, line_buffer_reset, mac_enable, adder_enable, final_filter_bank  out  1 each
- row_length  out  ADDR_FIFO  latched cfg_row_length
- shifting_filter  out  N_PE  one-hot filter-load strobe
- shifting_line_pool, line_buffer_reset_pool  out  1 each
- row_length_pool  out  ADDR_FIFO  row_length − K + 1
- pool_nl, nl_type  out  3 each; nl_enable, pool_enable  out  1 each

## Operation
- Reset: all outputs 0, state IDLE, counters and adder delay line cleared.
- start in IDLE: config is checked. K==0, K>KMAX, row_length<K, n_rows<K or n_banks==0 → err_cfg pulse the next cycle; stay IDLE; nothing latched. Otherwise latch config and enter LB_RST. start outside IDLE is ignored.
- States per bank b = 0..n_banks−1:
  - LB_RST: 1 cycle; line_buffer_reset=1; line_buffer_reset_pool=1 if pool_enable.
  - FLOAD: shifting_filter[p] for K·K valid cycles, p = 0..N_PE−1 in order; N_PE·K·K valid cycles total.
  - PRIME: shifting_line for (K−1)·row_length valid cycles.
  - ROW: n_rows−K+1 output rows × row_length valid cycles. shifting_line=1; mac_enable=1 when column ≥ K−1.
  - DRAIN: ADDER_LAT cycles, independent of data_valid.
  - Then, if b < n_banks−1: b++ → LB_RST; else → DONE (done=1 for 1 cycle) → IDLE.
- Strobes in FLOAD/PRIME/ROW are ANDed with data_valid in the same cycle. Counters advance only on valid cycles. Stalls have no length limit.
- adder_enable = mac_enable delayed by exactly ADDER_LAT cycles.
- shifting_line_pool = adder_enable & pool_enable.
- final_filter_bank = 1 in every non-IDLE state of the last bank.
- Latched row_length, row_length_pool, pool/nl fields are driven while busy. They are 0 in IDLE.
- rst mid-operation: reset values next cycle, in-flight adder_enable pipeline discarded, no done.

## Timing
- start sampled at edge t → LB_RST and busy=1 at t+1.
- Cycles per bank with no stalls: 1 + N_PE·K·K + (K−1)·row_length + (n_rows−K+1)·row_length + ADDER_LAT.
- done high in the cycle after the final DRAIN cycle. busy falls with done.
- A new start is accepted in the cycle after done.
- Counters are ADDR_FIFO/ROW_W/BANK_W wide plus a filter counter sized for N_PE·KMAX². No wrap-around is possible for legal configs.

## Test plan
- N_PE=4, K=3, row_length=8, n_rows=5, n_banks=2, data_valid=1, start at t=0 → done at t=159; 36 mac_enable pulses and 36 adder_enable pulses, each adder pulse 2 cycles after its mac pulse; final_filter_bank high only during bank 1.
- Same config with data_valid toggling 1/0 → the same strobe counts. Zero strobes occur while data_valid=0. The total cycle count grows by exactly the number of stalled cycles in FLOAD/PRIME/ROW.
- Illegal configs (K=0; K=6; row_length=2 with K=3; n_banks=0) → err_cfg single pulse, busy stays 0, all strobes 0.
- start pulsed again while busy → ignored; the run completes with the original config.
- rst asserted mid-ROW → all outputs 0 the next cycle, IDLE, no done; a fresh start then runs normally.
- pool_enable=1, K=1, row_length=4, n_rows=2, n_banks=1, N_PE=4 → shifting_line_pool mirrors adder_enable (8 pulses); row_length_pool=4; line_buffer_reset_pool pulses once.
